acl_txarq_bufctrl: RTL
======================

// Module: acl_txarq_bufctrl
// PURPOSE
// - TX-side ACL ARQ engine: per LT_ADDR (8 links) two-entry ping-pong payload queue, SEQN generation, new/old/NULL decision, flush.
// - Sits between the MCU buffer writer and the packet encoder.
// - Consumes decoded ARQN/FLOW of the returned header; the RX-side ARQN/SEQN_old tracker is the other end of this protocol.
// PARAMETERS
// - LEN_W   10  payload length width (bytes)
// - FLUSH_W 16  flush-timeout counter width (slots)
// PORTS
// clk_6M          in   1        6 MHz clock
// rstz            in   1        async reset, active-low
// conns_start_p   in   1        link (re)start; re-initialise all LT state
// init_seqn       in   1        SEQN loaded on conns_start_p (master 0, slave 1)
// mcu_load_p      in   1        MCU finished writing a payload for mcu_lt_addr
// mcu_flush_p     in   1        MCU flush command for mcu_lt_addr
// mcu_lt_addr     in   3        LT_ADDR of load/flush
// mcu_len         in   LEN_W    length of loaded payload
// flush_to        in   FLUSH_W  automatic flush timeout in slots; 0 = never
// slot_tick_p     in   1        one pulse per 625 us slot
// tx_slot_p       in   1        encoder requests payload decision for tx_lt_addr
// tx_lt_addr      in   3        LT_ADDR of the TX slot
// rx_hdr_p        in   1        returned header checked OK (HEC good, addressed)
// rx_lt_addr      in   3        LT_ADDR of returned header
// rx_arqn         in   1        decoded ARQN (1 = ACK)
// rx_flow         in   1        decoded FLOW (1 = GO)
// tx_haspy        out  1        1 = send ACL data; 0 = send NULL/POLL
// tx_pysel        out  1        buffer index (0/1) to read
// tx_pylen        out  LEN_W    payload length; 0 when tx_haspy=0
// tx_seqn         out  1        SEQN bit for the header
// tx_retx         out  1        payload is a retransmission
// buf_rdy         out  8        per LT: at least one free buffer
// load_ovf_p      out  1        load rejected, queue full
// buf_rel_p       out  1        head payload ACKed, buffer released
// buf_rel_lt      out  3        LT_ADDR of the release
// flush_done_p    out  8        per-LT flush-complete pulse
// txaclSEQN       out  8        current SEQN of every LT
// BEHAVIOUR
// - Per-LT state:
//   - cnt (0..2 queued)
//   - head (buffer index)
//   - sent (head transmitted, awaiting ACK)
//   - seqn
//   - flow_ok
//   - len[2]
//   - fcnt (FLUSH_W)
// - Reset: cnt=0, head=0, sent=0, seqn=0, flow_ok=1, fcnt=0. All outputs 0, except buf_rdy=8'hff.
// - conns_start_p: same as reset, but seqn <= init_seqn for all LTs. Takes priority over every other event in that cycle.
// - Load (mcu_load_p):
//   - cnt<2: write len into buffer head^(cnt==1), cnt+1.
//   - cnt==2: ignore; load_ovf_p for 1 cycle.
//   - buf_rdy[lt] = (cnt<2), combinational from state.
// - TX decision (tx_slot_p): outputs registered, valid 1 cycle after; held until next tx_slot_p.
//   - cnt>0 & flow_ok: tx_haspy=1, tx_pysel=head, tx_pylen=len[head], tx_retx=sent; then sent<=1.
//   - Otherwise: tx_haspy=0, tx_pylen=0, tx_retx=0.
//   - tx_seqn = seqn[lt] in both cases; a NULL never toggles SEQN.
// - ACK (rx_hdr_p):
//   - flow_ok[lt] <= rx_flow.
//   - rx_arqn & sent: release head. head^=1, cnt-1, sent=0, seqn toggles, fcnt=0; buf_rel_p with buf_rel_lt.
//   - NAK, or ACK with sent=0: no queue change. Head is resent on the next data slot.
//   - This also covers FLOW stop->go: the old payload is retransmitted.
// - Flush timer, per LT:
//   - On slot_tick_p with cnt>0, fcnt+1, saturating.
//   - fcnt=0 on release, on load into an empty queue, and on flush.
//   - flush_to!=0 & fcnt+1>=flush_to on a tick triggers flush.
// - Flush (timer or mcu_flush_p):
//   - cnt=0, sent=0, fcnt=0; seqn toggles iff sent was 1.
//   - flush_done_p[lt] for 1 cycle.
//   - Several LTs may flush in one cycle.
// - Same-LT, same-cycle ordering: tx decision uses pre-update state.
//   - Then release, then flush, then load.
//   - Release + flush: no buf_rel_p; seqn toggles once.
//   - Flush + load: queue ends with cnt=1, head = loaded buffer.
//   - Release + load with cnt==2: accepted; the load takes the just-freed buffer.
// - No other cross-LT interaction.
// TESTING
// 1. Reset, then conns_start_p with init_seqn=1 -> txaclSEQN=8'hff, buf_rdy=8'hff, tx_slot_p lt3 -> tx_haspy=0, tx_pylen=0, tx_seqn=1.
// 2. Load lt1 len=27; tx_slot_p -> haspy=1, pysel=0, len=27, retx=0; rx_hdr ACK -> buf_rel_p lt1, txaclSEQN[1] toggles, buf_rdy[1]=1.
// 3. Load lt2 twice, 3rd load -> load_ovf_p; NAK -> next tx retx=1 same pysel; rx_flow=0 -> next tx NULL; flow=1 -> retx=1 again.
// 4. flush_to=4, load lt5, tx once, no ACK -> flush_done_p[5] on 4th slot_tick, cnt=0, SEQN[5] toggled; repeat with no tx -> SEQN unchanged.
// 5. Same cycle: ACK lt0 (cnt=2) + mcu_load_p lt0 -> buf_rel_p, cnt stays 2, new len in freed buffer, no load_ovf_p.
// 6. Assert rstz low mid-retransmission -> all outputs to reset values next edge; first post-reset tx is NULL.

Source files
------------

// File: rtl/acl_txarq_bufctrl.sv
// TX-side ACL ARQ buffer controller: per-LT two-entry ping-pong payload queue, SEQN tracking,
// data/NULL decision, ACK-driven release and flush (MCU command or slot timeout).
module acl_txarq_bufctrl #(
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned FLUSH_W = 16
) (
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               conns_start_p,
  input  logic               init_seqn,
  input  logic               mcu_load_p,
  input  logic               mcu_flush_p,
  input  logic [2:0]         mcu_lt_addr,
  input  logic [LEN_W-1:0]   mcu_len,
  input  logic [FLUSH_W-1:0] flush_to,
  input  logic               slot_tick_p,
  input  logic               tx_slot_p,
  input  logic [2:0]         tx_lt_addr,
  input  logic               rx_hdr_p,
  input  logic [2:0]         rx_lt_addr,
  input  logic               rx_arqn,
  input  logic               rx_flow,
  output logic               tx_haspy,
  output logic               tx_pysel,
  output logic [LEN_W-1:0]   tx_pylen,
  output logic               tx_seqn,
  output logic               tx_retx,
  output logic [7:0]         buf_rdy,
  output logic               load_ovf_p,
  output logic               buf_rel_p,
  output logic [2:0]         buf_rel_lt,
  output logic [7:0]         flush_done_p,
  output logic [7:0]         txaclSEQN
);

  localparam int unsigned NumLt = 8;

  logic [1:0]         cnt_q  [NumLt];
  logic [1:0]         cnt_d  [NumLt];
  logic [LEN_W-1:0]   len_q  [NumLt][2];
  logic [LEN_W-1:0]   len_d  [NumLt][2];
  logic [FLUSH_W-1:0] fcnt_q [NumLt];
  logic [FLUSH_W-1:0] fcnt_d [NumLt];
  logic [NumLt-1:0]   head_q, head_d, sent_q, sent_d, seqn_q, seqn_d, flow_q, flow_d;
  logic [NumLt-1:0]   rel_v, tflush_v, flush_v;

  logic               tx_data;
  logic               tx_haspy_d, tx_pysel_d, tx_seqn_d, tx_retx_d;
  logic [LEN_W-1:0]   tx_pylen_d;
  logic               ovf_d, rel_d;
  logic [2:0]         rel_lt_d;
  logic [NumLt-1:0]   fd_d;

  always_comb begin
    tx_data    = (cnt_q[tx_lt_addr] != 2'd0) && flow_q[tx_lt_addr];
    tx_haspy_d = tx_haspy;
    tx_pysel_d = tx_pysel;
    tx_pylen_d = tx_pylen;
    tx_seqn_d  = tx_seqn;
    tx_retx_d  = tx_retx;
    ovf_d      = 1'b0;
    rel_d      = 1'b0;
    rel_lt_d   = buf_rel_lt;
    head_d     = head_q;
    sent_d     = sent_q;
    seqn_d     = seqn_q;
    flow_d     = flow_q;
    rel_v      = '0;
    tflush_v   = '0;
    flush_v    = '0;

    // Decision is taken on the state before any same-cycle update.
    if (tx_slot_p) begin
      tx_haspy_d = tx_data;
      tx_pysel_d = tx_data ? head_q[tx_lt_addr] : 1'b0;
      tx_pylen_d = tx_data ? len_q[tx_lt_addr][head_q[tx_lt_addr]] : '0;
      tx_retx_d  = tx_data ? sent_q[tx_lt_addr] : 1'b0;
      tx_seqn_d  = seqn_q[tx_lt_addr];
    end

    for (int i = 0; i < NumLt; i++) begin
      cnt_d[i]    = cnt_q[i];
      len_d[i][0] = len_q[i][0];
      len_d[i][1] = len_q[i][1];
      fcnt_d[i]   = fcnt_q[i];

      if (slot_tick_p && cnt_q[i] != 2'd0) begin
        if (~&fcnt_q[i]) fcnt_d[i] = fcnt_q[i] + FLUSH_W'(1);
        tflush_v[i] = (flush_to != '0) &&
                      (({1'b0, fcnt_q[i]} + (FLUSH_W+1)'(1)) >= {1'b0, flush_to});
      end

      if (tx_slot_p && tx_lt_addr == 3'(i) && tx_data) sent_d[i] = 1'b1;

      // Release acts on the head that was outstanding before this cycle.
      if (rx_hdr_p && rx_lt_addr == 3'(i)) begin
        flow_d[i] = rx_flow;
        if (rx_arqn && sent_q[i]) begin
          rel_v[i]  = 1'b1;
          head_d[i] = ~head_q[i];
          cnt_d[i]  = cnt_q[i] - 2'd1;
          sent_d[i] = 1'b0;
          seqn_d[i] = ~seqn_q[i];
          fcnt_d[i] = '0;
        end
      end

      flush_v[i] = tflush_v[i] | (mcu_flush_p && mcu_lt_addr == 3'(i));
      if (flush_v[i]) begin
        if (sent_d[i]) seqn_d[i] = ~seqn_d[i];
        cnt_d[i]  = 2'd0;
        sent_d[i] = 1'b0;
        fcnt_d[i] = '0;
      end

      if (mcu_load_p && mcu_lt_addr == 3'(i)) begin
        if (cnt_d[i] != 2'd2) begin
          len_d[i][head_d[i] ^ (cnt_d[i] == 2'd1)] = mcu_len;
          if (cnt_d[i] == 2'd0) fcnt_d[i] = '0;
          cnt_d[i] = cnt_d[i] + 2'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end

      if (rel_v[i] && !flush_v[i]) begin
        rel_d    = 1'b1;
        rel_lt_d = 3'(i);
      end
    end
    fd_d = flush_v;

    if (conns_start_p) begin
      for (int i = 0; i < NumLt; i++) begin
        cnt_d[i]  = 2'd0;
        fcnt_d[i] = '0;
      end
      head_d     = '0;
      sent_d     = '0;
      seqn_d     = {NumLt{init_seqn}};
      flow_d     = '1;
      tx_haspy_d = 1'b0;
      tx_pysel_d = 1'b0;
      tx_pylen_d = '0;
      tx_seqn_d  = 1'b0;
      tx_retx_d  = 1'b0;
      ovf_d      = 1'b0;
      rel_d      = 1'b0;
      rel_lt_d   = '0;
      fd_d       = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NumLt; i++) buf_rdy[i] = (cnt_q[i] != 2'd2);
  end

  assign txaclSEQN = seqn_q;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      for (int i = 0; i < NumLt; i++) begin
        cnt_q[i]    <= '0;
        fcnt_q[i]   <= '0;
        len_q[i][0] <= '0;
        len_q[i][1] <= '0;
      end
      head_q       <= '0;
      sent_q       <= '0;
      seqn_q       <= '0;
      flow_q       <= '1;
      tx_haspy     <= 1'b0;
      tx_pysel     <= 1'b0;
      tx_pylen     <= '0;
      tx_seqn      <= 1'b0;
      tx_retx      <= 1'b0;
      load_ovf_p   <= 1'b0;
      buf_rel_p    <= 1'b0;
      buf_rel_lt   <= '0;
      flush_done_p <= '0;
    end else begin
      for (int i = 0; i < NumLt; i++) begin
        cnt_q[i]    <= cnt_d[i];
        fcnt_q[i]   <= fcnt_d[i];
        len_q[i][0] <= len_d[i][0];
        len_q[i][1] <= len_d[i][1];
      end
      head_q       <= head_d;
      sent_q       <= sent_d;
      seqn_q       <= seqn_d;
      flow_q       <= flow_d;
      tx_haspy     <= tx_haspy_d;
      tx_pysel     <= tx_pysel_d;
      tx_pylen     <= tx_pylen_d;
      tx_seqn      <= tx_seqn_d;
      tx_retx      <= tx_retx_d;
      load_ovf_p   <= ovf_d;
      buf_rel_p    <= rel_d;
      buf_rel_lt   <= rel_lt_d;
      flush_done_p <= fd_d;
    end
  end

endmodule
